// File: rtl/sl_rx_fifo.sv
// Serial-line receiver: filters the two-wire SL bus, decodes ZERO/ONE/STOP bits,
// checks word length and odd parity, and queues words with status in a show-ahead FIFO.
module sl_rx_fifo #(
    parameter int OVS        = 16,
    parameter int STROBE_POS = 8,
    parameter int MAX_BITS   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MAX    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sl_zero_a,
    input  logic                          sl_one_a,
    input  logic                          cfg_we,
    input  logic [5:0]                    cfg_len,
    input  logic                          cfg_par_en,
    output logic [5:0]                    cfg_len_o,
    output logic                          cfg_par_o,
    output logic                          busy,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [MAX_BITS-1:0]           rx_data,
    output logic [2:0]                    rx_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(2*OVS+1);
    localparam int GW  = $clog2(GAP_MAX+1);
    localparam int BCW = $clog2(MAX_BITS+2);
    localparam int unsigned MB = MAX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_END, S_GAP, S_PUSH} state_t;

    state_t state_q, state_d;

    logic [1:0] z_sync, o_sync;
    logic [2:0] z_hist, o_hist;
    logic       z_f, o_f, z_fd, o_fd;
    logic       fall, line_idle;

    logic [CW-1:0]       cnt_q;
    logic [GW-1:0]       gap_q;
    logic [BCW-1:0]      bit_cnt_q;
    logic [MAX_BITS:0]   shreg_q;
    logic                par_q, ovr_q;
    logic [MAX_BITS-1:0] ent_data_q, ent_data_d, ev_data;
    logic [2:0]          ent_err_q, ent_err_d, ev_err;
    logic                load_ent, shift_en, bit_val, len_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_sync <= '1; o_sync <= '1;
            z_hist <= '1; o_hist <= '1;
            z_f <= 1'b1; o_f <= 1'b1; z_fd <= 1'b1; o_fd <= 1'b1;
        end else begin
            z_sync <= {z_sync[0], sl_zero_a};
            o_sync <= {o_sync[0], sl_one_a};
            z_hist <= {z_hist[1:0], z_sync[1]};
            o_hist <= {o_hist[1:0], o_sync[1]};
            z_f  <= (z_hist[0] & z_hist[1]) | (z_hist[0] & z_hist[2]) | (z_hist[1] & z_hist[2]);
            o_f  <= (o_hist[0] & o_hist[1]) | (o_hist[0] & o_hist[2]) | (o_hist[1] & o_hist[2]);
            z_fd <= z_f;
            o_fd <= o_f;
        end
    end

    assign fall      = (z_fd & ~z_f) | (o_fd & ~o_f);
    assign line_idle = z_f & o_f;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        len_ok  = !ovr_q && (7'(bit_cnt_q) == 7'(cfg_len_o) + 7'd1);
        ev_data = '0;
        ev_err  = '0;
        if (!len_ok)
            ev_err = 3'b010;
        else if (cfg_par_o && !par_q)
            ev_err = 3'b001;
        else
            for (int unsigned i = 0; i < MB; i++)
                if (i < 32'(cfg_len_o)) ev_data[i] = shreg_q[i];
    end

    always_comb begin
        state_d    = state_q;
        load_ent   = 1'b0;
        ent_data_d = '0;
        ent_err_d  = '0;
        shift_en   = 1'b0;
        bit_val    = 1'b0;
        case (state_q)
            S_IDLE: if (fall) state_d = S_START;
            S_START:
                if (cnt_q == CW'(STROBE_POS)) begin
                    case ({z_f, o_f})
                        2'b01: begin shift_en = 1'b1; bit_val = 1'b0; state_d = S_WAIT_END; end
                        2'b10: begin shift_en = 1'b1; bit_val = 1'b1; state_d = S_WAIT_END; end
                        2'b00: begin
                            load_ent = 1'b1; ent_data_d = ev_data; ent_err_d = ev_err; state_d = S_PUSH;
                        end
                        default: begin load_ent = 1'b1; ent_err_d = 3'b100; state_d = S_PUSH; end
                    endcase
                end
            // After a push bit_cnt is 0: just wait for the bus to go idle, no timeout or gap abort.
            S_WAIT_END:
                if (line_idle)
                    state_d = (bit_cnt_q == '0) ? S_IDLE : S_GAP;
                else if (bit_cnt_q != '0 && cnt_q == CW'(2*OVS)) begin
                    load_ent = 1'b1; ent_err_d = 3'b100; state_d = S_PUSH;
                end
            S_GAP:
                if (fall)
                    state_d = S_START;
                else if (gap_q == GW'(GAP_MAX)) begin
                    load_ent = 1'b1; ent_err_d = 3'b010; state_d = S_PUSH;
                end
            S_PUSH: state_d = line_idle ? S_IDLE : S_WAIT_END;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ent_data_q <= '0;
            ent_err_q  <= '0;
            cfg_len_o  <= 6'd8;
            cfg_par_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE || state_q == S_GAP || state_q == S_PUSH)
                cnt_q <= '0;
            else if (cnt_q != CW'(2*OVS))
                cnt_q <= cnt_q + 1'b1;
            if (state_q != S_GAP)
                gap_q <= '0;
            else if (gap_q != GW'(GAP_MAX))
                gap_q <= gap_q + 1'b1;
            if (state_q == S_PUSH) begin
                shreg_q   <= '0;
                bit_cnt_q <= '0;
                par_q     <= 1'b0;
                ovr_q     <= 1'b0;
            end else if (shift_en) begin
                if (bit_cnt_q == BCW'(MAX_BITS+1))
                    ovr_q <= 1'b1;
                else begin
                    shreg_q[bit_cnt_q] <= bit_val;
                    bit_cnt_q          <= bit_cnt_q + 1'b1;
                    par_q              <= par_q ^ bit_val;
                end
            end
            if (load_ent) begin
                ent_data_q <= ent_data_d;
                ent_err_q  <= ent_err_d;
            end
            if (cfg_we && !busy && cfg_len >= 6'd8 && 7'(cfg_len) <= 7'(MAX_BITS)) begin
                cfg_len_o <= cfg_len;
                cfg_par_o <= cfg_par_en;
            end
        end
    end

    logic [MAX_BITS-1:0] mem_data [FIFO_DEPTH];
    logic [2:0]          mem_err  [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                push, pop, full, wr_en;

    assign push  = (state_q == S_PUSH);
    assign pop   = rx_valid & rx_ready;
    assign full  = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= ent_data_q;
            mem_err[wr_ptr]  <= ent_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    assign rx_valid = (fifo_level != '0);
    assign rx_data  = rx_valid ? mem_data[rd_ptr] : '0;
    assign rx_err   = rx_valid ? mem_err[rd_ptr]  : '0;

endmodule

// File: tb/tb_sl_rx_fifo.sv
// Directed self-checking bench for sl_rx_fifo with default parameters.
module tb_sl_rx_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sl_zero_a = 1'b1, sl_one_a = 1'b1;
    logic        cfg_we = 1'b0, cfg_par_en = 1'b0;
    logic [5:0]  cfg_len = 6'd8;
    logic [5:0]  cfg_len_o;
    logic        cfg_par_o, busy, rx_valid, overflow;
    logic        rx_ready = 1'b0, ovf_clr = 1'b0;
    logic [31:0] rx_data;
    logic [2:0]  rx_err;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_mis = 0;

    sl_rx_fifo #(.OVS(16), .STROBE_POS(8), .MAX_BITS(32), .FIFO_DEPTH(4), .GAP_MAX(64)) dut (
        .clk(clk), .rst_n(rst_n), .sl_zero_a(sl_zero_a), .sl_one_a(sl_one_a),
        .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_par_en(cfg_par_en),
        .cfg_len_o(cfg_len_o), .cfg_par_o(cfg_par_o), .busy(busy),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_err(rx_err),
        .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        if (b) sl_one_a = 1'b0; else sl_zero_a = 1'b0;
        cycles(12);
        sl_zero_a = 1'b1; sl_one_a = 1'b1;
        cycles(4);
    endtask

    task automatic send_stop();
        @(negedge clk);
        sl_zero_a = 1'b0; sl_one_a = 1'b0;
        cycles(12);
        sl_zero_a = 1'b1; sl_one_a = 1'b1;
        cycles(4);
    endtask

    task automatic send_word(input logic [31:0] d, input int n, input logic p);
        for (int i = 0; i < n; i++) send_bit(d[i]);
        send_bit(p);
        send_stop();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!rx_valid && k < budget) begin @(negedge clk); k++; end
        if (!rx_valid) check({tag, "_timeout"}, 32'(rx_valid), 32'd1);
    endtask

    task automatic pop();
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] len, input logic pe);
        @(negedge clk); cfg_we = 1'b1; cfg_len = len; cfg_par_en = pe;
        @(negedge clk); cfg_we = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] d, input logic [2:0] e, input int lvl);
        check({tag, "_data"}, rx_data, d);
        check({tag, "_err"}, 32'(rx_err), 32'(e));
        check({tag, "_level"}, 32'(fifo_level), 32'(lvl));
    endtask

    initial begin
        logic [31:0] w [5];
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h34; w[3] = 32'h47; w[4] = 32'h5E;

        cycles(3);
        check("rst_len", 32'(cfg_len_o), 32'd8);
        check("rst_par", 32'(cfg_par_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", rx_data, 32'd0);
        check("rst_err", 32'(rx_err), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        cycles(4);

        // T1: 0xA5 with odd parity bit 1
        send_word(32'hA5, 8, 1'b1);
        wait_valid("t1", 40);
        check_head("t1", 32'hA5, 3'b000, 1);
        pop();
        check("t1_empty", 32'(rx_valid), 32'd0);

        // T2: parity check enabled, wrong parity bit
        cfg_write(6'd8, 1'b1);
        check("t2_par_on", 32'(cfg_par_o), 32'd1);
        send_word(32'hA5, 8, 1'b0);
        wait_valid("t2a", 40);
        check_head("t2a", 32'h0, 3'b001, 1);
        pop();
        cfg_write(6'd8, 1'b0);
        send_word(32'hA5, 8, 1'b0);
        wait_valid("t2b", 40);
        check_head("t2b", 32'hA5, 3'b000, 1);
        pop();

        // T3: config write while busy is ignored
        send_bit(1'b1);
        check("t3_busy", 32'(busy), 32'd1);
        cfg_write(6'd16, 1'b0);
        check("t3_len_busy", 32'(cfg_len_o), 32'd8);
        for (int i = 1; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h1) != 0);
        send_bit(1'b1);
        send_stop();
        wait_valid("t3a", 40);
        check_head("t3a", 32'hA5, 3'b000, 1);
        pop();
        cycles(20);
        cfg_write(6'd16, 1'b0);
        check("t3_len_idle", 32'(cfg_len_o), 32'd16);
        cfg_write(6'd7, 1'b0);
        check("t3_len_lo", 32'(cfg_len_o), 32'd16);
        cfg_write(6'd33, 1'b0);
        check("t3_len_hi", 32'(cfg_len_o), 32'd16);
        send_word(32'hFF, 8, 1'b0);
        wait_valid("t3b", 40);
        check_head("t3b", 32'h0, 3'b010, 1);
        pop();
        cycles(20);
        cfg_write(6'd32, 1'b0);
        check("t3_len_max", 32'(cfg_len_o), 32'd32);
        cfg_write(6'd8, 1'b0);

        // T4: 1-cycle glitch filtered, 3-cycle pulse on both lines gives level error
        @(negedge clk); sl_zero_a = 1'b0;
        @(negedge clk); sl_zero_a = 1'b1;
        cycles(3);
        check("t4_glitch_busy", 32'(busy), 32'd0);
        cycles(20);
        check("t4_glitch_level", 32'(fifo_level), 32'd0);
        @(negedge clk); sl_zero_a = 1'b0; sl_one_a = 1'b0;
        cycles(3);
        sl_zero_a = 1'b1; sl_one_a = 1'b1;
        cycles(4);
        check("t4_pulse_busy", 32'(busy), 32'd1);
        wait_valid("t4", 40);
        check_head("t4", 32'h0, 3'b100, 1);
        pop();

        // T5: 5 bits then silence triggers gap abort
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        wait_valid("t5", 150);
        check_head("t5", 32'h0, 3'b010, 1);
        cycles(3);
        check("t5_busy", 32'(busy), 32'd0);

        // reset mid-word empties the FIFO and aborts the word
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        cycles(4);

        // T6: overflow, clear, in-order pops
        for (int i = 0; i < 5; i++) send_word(w[i], 8, ~(^w[i][7:0]));
        cycles(4);
        check("t6_level", 32'(fifo_level), 32'd4);
        check("t6_ovf", 32'(overflow), 32'd1);
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        check("t6_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("t6_pop%0d", i), w[i], 3'b000, 4 - i);
            pop();
        end
        check("t6_empty", 32'(rx_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
